// File: rtl/alu_wb_pkg.sv
// alu_wb_pkg: shared opcodes, FSM states and sizing for the ALU writeback stage
package alu_wb_pkg;
  localparam int WORD_W = 8;
  localparam int REG_ADDR_W = 3;
  localparam int MUL_STEPS = WORD_W;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDI = 3'd5;
  localparam logic [2:0] OP_SHR = 3'd6;
  localparam logic [2:0] OP_MUL = 3'd7;
  typedef enum logic {IDLE, MUL_BUSY} state_t;
endpackage

// File: rtl/seq_shift_add_mul.sv
// seq_shift_add_mul: iterative multiplier, one shift-add step per cycle over DATA_W cycles
module seq_shift_add_mul
  import alu_wb_pkg::*;
#(
  parameter int DATA_W = WORD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     a,
  input  logic [DATA_W-1:0]     b,
  output logic                  busy,
  output logic                  done,
  output logic [2*DATA_W-1:0]   product
);
  localparam int CW = $clog2(DATA_W + 1);
  logic [2*DATA_W-1:0] ma, acc, acc_next;
  logic [DATA_W-1:0]   mb;
  logic [CW-1:0]       cnt;
  // the product presented with done already includes the final step
  always_comb acc_next = acc + (mb[0] ? ma : '0);
  assign product = acc_next;
  assign done = busy && (cnt == CW'(DATA_W - 1));
  // load operands on start, then add the shifted multiplicand for each set multiplier bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ma   <= '0;
      mb   <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start && !busy) begin
      ma   <= {{DATA_W{1'b0}}, a};
      mb   <= b;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      acc  <= acc_next;
      ma   <= ma << 1;
      mb   <= mb >> 1;
      cnt  <= cnt + 1'b1;
      busy <= !done;
    end
  end
endmodule

// File: rtl/alu_writeback_stage.sv
// alu_writeback_stage: execute/writeback stage with forwarding and a stalling multiplier
module alu_writeback_stage
  import alu_wb_pkg::*;
#(
  parameter int DATA_W = WORD_W,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] rd,
  input  logic [ADDR_W-1:0] rs1,
  input  logic [ADDR_W-1:0] rs2,
  input  logic [DATA_W-1:0] imm,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_en,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              zero_flag,
  output logic              carry_flag
);
  state_t state_q, state_d;
  logic [DATA_W-1:0]   a, b, res, wb_data;
  logic [DATA_W:0]     sum, diff;
  logic                cy, wb_carry, wb_go, accept, mul_start, mul_busy, mul_done;
  logic [ADDR_W-1:0]   mul_rd, wb_addr;
  logic [2*DATA_W-1:0] product;
  assign rf_raddr1 = rs1;
  assign rf_raddr2 = rs2;
  assign instr_ready = !rst && state_q == IDLE && !mul_busy;
  assign accept = instr_valid && instr_ready;
  assign mul_start = accept && opcode == OP_MUL;
  // forward the value being written this cycle so back-to-back dependencies see it
  always_comb begin
    a = (rf_en && rf_waddr == rs1) ? rf_wdata : rf_rdata1;
    b = (rf_en && rf_waddr == rs2) ? rf_wdata : rf_rdata2;
  end
  // single-cycle ALU; carry carries borrow for SUB and the shifted-out bit for SHR
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} - {1'b0, b};
    res  = opcode == OP_ADD ? sum[DATA_W-1:0] :
           opcode == OP_SUB ? diff[DATA_W-1:0] :
           opcode == OP_AND ? a & b :
           opcode == OP_OR  ? a | b :
           opcode == OP_XOR ? a ^ b :
           opcode == OP_LDI ? imm :
           opcode == OP_SHR ? a >> 1 : '0;
    cy   = opcode == OP_ADD ? sum[DATA_W] :
           opcode == OP_SUB ? diff[DATA_W] :
           opcode == OP_SHR ? a[0] : 1'b0;
  end
  seq_shift_add_mul #(.DATA_W(DATA_W)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );
  // next state: a multiply holds issue until its final step completes
  always_comb begin
    state_d = state_q;
    state_d = (state_q == IDLE && mul_start) ? MUL_BUSY :
              (state_q == MUL_BUSY && mul_done) ? IDLE : state_q;
  end
  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else state_q <= state_d;
  end
  // remember the multiply destination for its delayed writeback
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mul_rd <= '0;
    else if (mul_start) mul_rd <= rd;
  end
  // choose the writeback source: a completing multiply or a single-cycle op
  always_comb begin
    wb_go    = (accept && opcode != OP_MUL) || mul_done;
    wb_data  = mul_done ? product[DATA_W-1:0] : res;
    wb_carry = mul_done ? |product[2*DATA_W-1:DATA_W] : cy;
    wb_addr  = mul_done ? mul_rd : rd;
  end
  // register the write port; flags only move when a result is written
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rf_en      <= 1'b0;
      rf_waddr   <= '0;
      rf_wdata   <= '0;
      zero_flag  <= 1'b0;
      carry_flag <= 1'b0;
    end else begin
      rf_en <= wb_go;
      if (wb_go) begin
        rf_waddr   <= wb_addr;
        rf_wdata   <= wb_data;
        zero_flag  <= wb_data == '0;
        carry_flag <= wb_carry;
      end
    end
  end
endmodule
